ring_counter_top_2: RTL and testbench

//   Knight Rider style bouncing ring counter. A single lit bit walks from LSB to
//   MSB, then back from MSB to LSB, and repeats. Top-level LED driver block.

---
 rtl/ring_counter_top_2.sv | 63 ++++++
 tb/tb_ring_counter_top_2.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ring_counter_top_2.sv
// Knight Rider style bouncing ring counter: one lit bit sweeps LSB->MSB->LSB,
// advancing once per DIV clocks. Output is registered.
module ring_counter_top_2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk_i,
  input  logic             sys_rst_n_i,
  output logic [WIDTH-1:0] counter_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  dir_e             dir_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tick_c;
  logic             onehot_c;

  // Prescaler terminal count and one-hot sanity of the current pattern
  always_comb begin
    tick_c   = (cnt_q == CNT_MAX);
    onehot_c = (counter_o != '0) &&
               ((counter_o & (counter_o - WIDTH'(1))) == '0);
  end

  // Reset input is active-high despite its name; reset wins over any step
  always_ff @(posedge clk_i) begin
    if (sys_rst_n_i) begin
      cnt_q     <= '0;
      counter_o <= WIDTH'(1);
      dir_q     <= DIR_UP;
    end else begin
      cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
      if (tick_c) begin
        if (!onehot_c) begin
          counter_o <= WIDTH'(1);
          dir_q     <= DIR_UP;
        end else if (dir_q == DIR_UP) begin
          if (counter_o[WIDTH-1]) begin
            counter_o <= counter_o >> 1;
            dir_q     <= DIR_DOWN;
          end else begin
            counter_o <= counter_o << 1;
          end
        end else begin
          if (counter_o[0]) begin
            counter_o <= counter_o << 1;
            dir_q     <= DIR_UP;
          end else begin
            counter_o <= counter_o >> 1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ring_counter_top_2.sv
// Scoreboard bench for ring_counter_top_2: a DIV=1 and a DIV=4 instance run
// side by side against a position-based sweep model.
module tb_ring_counter_top_2;

  localparam int W = 8;
  localparam int PERIOD = 2 * (W - 1);

  logic         clk;
  logic         rst1;
  logic         rst4;
  logic [W-1:0] cnt1;
  logic [W-1:0] cnt4;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q4[$];

  int pos1 = 0, pre1 = 0, pos4 = 0, pre4 = 0;

  logic [W-1:0] prev1, prev4;
  logic         pdir1, pdir4;
  bit           primed = 0;

  ring_counter_top_2 #(.WIDTH(W), .DIV(1)) dut1 (
    .clk_i       (clk),
    .sys_rst_n_i (rst1),
    .counter_o   (cnt1)
  );

  ring_counter_top_2 #(.WIDTH(W), .DIV(4)) dut4 (
    .clk_i       (clk),
    .sys_rst_n_i (rst4),
    .counter_o   (cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pattern as a function of sweep position 0..PERIOD-1
  function automatic logic [W-1:0] led_of(input int p);
    int b;
    logic [W-1:0] one;
    one = W'(1);
    b = (p < W) ? p : PERIOD - p;
    return one << b;
  endfunction

  task automatic model_step(input logic r, input int div, inout int pos, inout int pre);
    if (r) begin
      pos = 0;
      pre = 0;
    end else if (pre == div - 1) begin
      pre = 0;
      pos = (pos + 1) % PERIOD;
    end else begin
      pre = pre + 1;
    end
  endtask

  task automatic dir_chk(input string tag, input logic r, input logic [W-1:0] pc,
                         input logic pd, input logic cd);
    logic ok;
    if (r) ok = (cd == 1'b0);
    else if (pd != cd) ok = (pd == 1'b0 && pc[W-1]) || (pd == 1'b1 && pc[0]);
    else ok = 1'b1;
    chk(tag, 32'(ok), 32'd1);
  endtask

  // Drive one clock of stimulus, push model expectations, then score the edge
  task automatic cycle(input logic r1, input logic r4);
    logic d1, d4;
    rst1 = r1;
    rst4 = r4;
    model_step(r1, 1, pos1, pre1);
    model_step(r4, 4, pos4, pre4);
    exp_q1.push_back(led_of(pos1));
    exp_q4.push_back(led_of(pos4));
    @(posedge clk);
    #1;
    if (exp_q1.size() == 0) chk("sb1_empty", 32'd0, 32'd1);
    else chk("seq_div1", 32'(cnt1), 32'(exp_q1.pop_front()));
    if (exp_q4.size() == 0) chk("sb4_empty", 32'd0, 32'd1);
    else chk("seq_div4", 32'(cnt4), 32'(exp_q4.pop_front()));
    chk("onehot1", 32'($onehot(cnt1)), 32'd1);
    chk("onehot4", 32'($onehot(cnt4)), 32'd1);
    d1 = dut1.dir_q;
    d4 = dut4.dir_q;
    if (primed) begin
      dir_chk("dir1", r1, prev1, pdir1, d1);
      dir_chk("dir4", r4, prev4, pdir4, d4);
    end
    prev1  = cnt1;
    prev4  = cnt4;
    pdir1  = d1;
    pdir4  = d4;
    primed = 1;
  endtask

  initial begin
    int guard;
    rst1 = 1'b1;
    rst4 = 1'b1;

    // Reset held for two edges, then free-running sweep twice over
    cycle(1, 1);
    cycle(1, 1);
    for (int i = 0; i < 2 * PERIOD; i++) cycle(0, 0);

    // Walk DIV=1 instance to 0x20 on the way down, then pulse its reset
    guard = 0;
    while (pos1 != W + 1 && guard < 2 * PERIOD) begin
      cycle(0, 0);
      guard++;
    end
    chk("reach_20_down", 32'(cnt1), 32'h20);
    cycle(1, 0);
    cycle(0, 0);
    cycle(0, 0);

    // Reset DIV=4 instance mid-prescale, then let both run
    cycle(0, 0);
    cycle(0, 1);
    for (int i = 0; i < 12; i++) cycle(0, 0);

    // Sparse random resets on either instance
    for (int i = 0; i < 120; i++)
      cycle(logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 15) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
